id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the vector ASIP core, directly upstream of the forwarding unit.
- Captures register-file operands, source/destination register numbers and the ExtndSel operand-class code from decode, then presents them to the forwarding unit one cycle later.
- Owns load-use hazard detection: when a load in this stage feeds the next instruction's operand, it holds fetch/decode and inserts bubbles for LOAD_STALL cycles.
- Also honours pipeline flush (taken branch) and global hold (memory busy).

Parameters:
W, 32, operand data width
RA, 4, register-number width
CTRLW, 8, opaque execute-control bundle width (ALU op, vector mode, etc.)
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of the decode instruction (branch taken)
hold  in  1  global freeze (memory busy); all state retained
valid_d  in  1  decode slot holds a real instruction
R2val_d  in  W  register-file read data, source 2
R3val_d  in  W  register-file read data, source 3
R2_d  in  RA  source-2 register number
R3_d  in  RA  source-3 register number
DestR_d  in  RA  destination register number
ExtndSel_d  in  2  operand class: 1x = R2 is a register; 10 = R3 is also a register (DT); 11 = DI; 0x = no register source
MemRead_d  in  1  instruction is a load
RegWrite_d  in  1  instruction writes DestR
Ctrl_d  in  CTRLW  execute-control bundle
R2res1  out  W  registered source-2 data to forwarding unit
R3res1  out  W  registered source-3 data to forwarding unit
R2_2  out  RA  registered source-2 number
R3_2  out  RA  registered source-3 number
ExtndSel1  out  2  registered operand class
DestR_2  out  RA  registered destination
MemRead_2  out  1  registered load flag
RegWrite_2  out  1  registered write flag
Ctrl_2  out  CTRLW  registered control bundle
valid_2  out  1  stage holds a real instruction
stall_d  out  1  combinational: fetch/decode must hold the current instruction

Behaviour:
- Reset (async, rst=1): every registered output = 0, FSM = RUN, stall counter = 0. stall_d = 0 while in reset.
- Bubble: valid_2, MemRead_2 and RegWrite_2 = 0. ExtndSel1 = 00. R2_2, R3_2 and DestR_2 = 0. Data and Ctrl = 0. Register 0 never matches, so the forwarding unit ignores bubbles.
- Hazard term (combinational) = valid_2 & MemRead_2 & RegWrite_2 & (DestR_2 != 0) & valid_d & A, where A is either of:
  - (R2_d == DestR_2) & ExtndSel_d[1]
  - (R3_d == DestR_2) & (ExtndSel_d == 2'b10)
- FSM states: RUN, STALL.
  - RUN, no hazard: capture decode fields. valid_2 = valid_d; when valid_d = 0, capture a bubble.
  - RUN, hazard: capture a bubble, cnt <= LOAD_STALL-1. Next state is STALL if LOAD_STALL > 1, else RUN.
  - STALL: capture a bubble. cnt decrements each cycle; return to RUN in the cycle after cnt reaches 0.
- stall_d = (RUN & hazard) | STALL, gated to 0 by flush.
- Priority: rst > flush > hold > hazard/FSM.
  - flush: capture a bubble, FSM = RUN, cnt = 0, stall_d = 0. Applies even with hold = 1.
  - hold (no flush): all registers, FSM and cnt frozen. stall_d keeps its combinational value.
- Latency: exactly 1 cycle from decode inputs to stage outputs when there is no stall or hold.
- Re-evaluation after bubbles: the hazard term is evaluated again in RUN. The captured load has left the stage, so the held instruction proceeds.
- Data is captured unmodified; no width conversion.

Test Plan:
1. Reset: assert rst mid-stream with valid_2 = 1 -> all outputs 0 immediately (async), stall_d = 0. Release rst, then issue R2_d=3, DestR_d=5, R2val_d=0xAABBCCDD -> next edge gives R2_2=3, DestR_2=5, R2res1=0xAABBCCDD, valid_2=1.
2. Load-use on R2, LOAD_STALL=1:
   - Cycle N: load DestR=4. Cycle N+1: decode R2_d=4, ExtndSel_d=10.
   - Required: stall_d=1 for exactly one cycle, one bubble (valid_2=0, R2_2=0).
   - Then the dependent instruction appears with R2_2=4.
3. R3 hazard gating, load DestR=6 followed by R3_d=6:
   - ExtndSel_d=10 -> stall.
   - ExtndSel_d=11 (DI) -> no stall.
   - ExtndSel_d=01 with R2_d=6 -> no stall.
   - Load to register 0 -> never a stall.
4. LOAD_STALL=3 -> three consecutive bubbles, stall_d high for 3 cycles, then normal capture.
5. Flush during STALL (LOAD_STALL=3, flush in the second bubble cycle) -> bubble, FSM back to RUN, stall_d=0 that cycle, the next decode instruction is captured on the following edge.
6. Hold:
   - hold=1 for 4 cycles while R2res1=0x12345678 -> outputs unchanged, cnt frozen mid-stall.
   - Release hold -> the remaining stall cycles complete.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register. It also owns load-use hazard detection,
// bubble insertion, branch flush and global hold.
module id_ex_stage #(
  parameter int W          = 32,
  parameter int RA         = 4,
  parameter int CTRLW      = 8,
  parameter int LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             valid_d,
  input  logic [W-1:0]     R2val_d,
  input  logic [W-1:0]     R3val_d,
  input  logic [RA-1:0]    R2_d,
  input  logic [RA-1:0]    R3_d,
  input  logic [RA-1:0]    DestR_d,
  input  logic [1:0]       ExtndSel_d,
  input  logic             MemRead_d,
  input  logic             RegWrite_d,
  input  logic [CTRLW-1:0] Ctrl_d,
  output logic [W-1:0]     R2res1,
  output logic [W-1:0]     R3res1,
  output logic [RA-1:0]    R2_2,
  output logic [RA-1:0]    R3_2,
  output logic [1:0]       ExtndSel1,
  output logic [RA-1:0]    DestR_2,
  output logic             MemRead_2,
  output logic             RegWrite_2,
  output logic [CTRLW-1:0] Ctrl_2,
  output logic             valid_2,
  output logic             stall_d
);

  localparam int CW = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_STALL - 1);
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [W-1:0]     r_r2val;
  logic [W-1:0]     r_r3val;
  logic [RA-1:0]    r_r2;
  logic [RA-1:0]    r_r3;
  logic [1:0]       r_extsel;
  logic [RA-1:0]    r_destr;
  logic             r_memread;
  logic             r_regwrite;
  logic [CTRLW-1:0] r_ctrl;
  logic             r_valid;
  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;

  logic [W-1:0]     w_r2val_next;
  logic [W-1:0]     w_r3val_next;
  logic [RA-1:0]    w_r2_next;
  logic [RA-1:0]    w_r3_next;
  logic [1:0]       w_extsel_next;
  logic [RA-1:0]    w_destr_next;
  logic             w_memread_next;
  logic             w_regwrite_next;
  logic [CTRLW-1:0] w_ctrl_next;
  logic             w_valid_next;
  logic [0:0]       w_state_next;
  logic [CW-1:0]    w_cnt_next;

  logic w_load_in_ex;
  logic w_r2_match;
  logic w_r3_match;
  logic w_hazard;
  logic w_capture;

  // Register 0 is never a real producer, so a load to r0 cannot cause a stall.
  assign w_load_in_ex = r_valid & r_memread & r_regwrite & (r_destr != '0);
  assign w_r2_match   = (R2_d == r_destr) & ExtndSel_d[1];
  assign w_r3_match   = (R3_d == r_destr) & (ExtndSel_d == 2'b10);
  assign w_hazard     = w_load_in_ex & valid_d & (w_r2_match | w_r3_match);

  assign w_capture = (r_state == S_RUN) & ~w_hazard & valid_d;
  assign stall_d   = ~rst & ~flush & (((r_state == S_RUN) & w_hazard) | (r_state == S_STALL));

  // Anything not captured becomes an all-zero bubble.
  always_comb begin
    w_r2val_next    = '0;
    w_r3val_next    = '0;
    w_r2_next       = '0;
    w_r3_next       = '0;
    w_extsel_next   = '0;
    w_destr_next    = '0;
    w_memread_next  = 1'b0;
    w_regwrite_next = 1'b0;
    w_ctrl_next     = '0;
    w_valid_next    = 1'b0;
    if (w_capture) begin
      w_r2val_next    = R2val_d;
      w_r3val_next    = R3val_d;
      w_r2_next       = R2_d;
      w_r3_next       = R3_d;
      w_extsel_next   = ExtndSel_d;
      w_destr_next    = DestR_d;
      w_memread_next  = MemRead_d;
      w_regwrite_next = RegWrite_d;
      w_ctrl_next     = Ctrl_d;
      w_valid_next    = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (w_hazard) begin
          w_cnt_next   = CNT_INIT;
          w_state_next = (LOAD_STALL > 1) ? S_STALL : S_RUN;
        end
      end
      default: begin
        // Leaving on the 1->0 step makes the stall last exactly LOAD_STALL cycles.
        if (r_cnt > CW'(1)) begin
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          w_cnt_next   = '0;
          w_state_next = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r2val    <= '0;
      r_r3val    <= '0;
      r_r2       <= '0;
      r_r3       <= '0;
      r_extsel   <= '0;
      r_destr    <= '0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_state    <= S_RUN;
      r_cnt      <= '0;
    end else if (flush) begin
      r_r2val    <= '0;
      r_r3val    <= '0;
      r_r2       <= '0;
      r_r3       <= '0;
      r_extsel   <= '0;
      r_destr    <= '0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_valid    <= 1'b0;
      r_state    <= S_RUN;
      r_cnt      <= '0;
    end else if (!hold) begin
      r_r2val    <= w_r2val_next;
      r_r3val    <= w_r3val_next;
      r_r2       <= w_r2_next;
      r_r3       <= w_r3_next;
      r_extsel   <= w_extsel_next;
      r_destr    <= w_destr_next;
      r_memread  <= w_memread_next;
      r_regwrite <= w_regwrite_next;
      r_ctrl     <= w_ctrl_next;
      r_valid    <= w_valid_next;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign R2res1     = r_r2val;
  assign R3res1     = r_r3val;
  assign R2_2       = r_r2;
  assign R3_2       = r_r3;
  assign ExtndSel1  = r_extsel;
  assign DestR_2    = r_destr;
  assign MemRead_2  = r_memread;
  assign RegWrite_2 = r_regwrite;
  assign Ctrl_2     = r_ctrl;
  assign valid_2    = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_STALL = 1 and 3) share stimulus,
// each checked against a behavioural model every cycle.
module tb_id_ex_stage;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        valid;
    logic [31:0] r2v;
    logic [31:0] r3v;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic [3:0]  dst;
    logic [1:0]  ext;
    logic        mr;
    logic        rw;
    logic [7:0]  ctrl;
  } din_t;

  typedef struct packed {
    logic [31:0] r2v;
    logic [31:0] r3v;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic [1:0]  ext;
    logic [3:0]  dst;
    logic        mr;
    logic        rw;
    logic [7:0]  ctrl;
    logic        valid;
  } stg_t;

  typedef struct {
    din_t        in;
    logic        e_stall;
    logic        e_valid;
    logic [3:0]  e_r2;
    logic [3:0]  e_dst;
    logic [31:0] e_r2v;
  } vec_t;

  logic clk;
  logic rst;
  din_t din;

  logic [31:0] o_r2res [2];
  logic [31:0] o_r3res [2];
  logic [3:0]  o_r2    [2];
  logic [3:0]  o_r3    [2];
  logic [1:0]  o_ext   [2];
  logic [3:0]  o_dst   [2];
  logic        o_mr    [2];
  logic        o_rw    [2];
  logic [7:0]  o_ctrl  [2];
  logic        o_valid [2];
  logic        o_stall [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic last_stall [2];

  stg_t m_stg  [2];
  int   m_left [2];

  vec_t tbl [16];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      id_ex_stage #(
        .W(32), .RA(4), .CTRLW(8), .LOAD_STALL(gi == 0 ? 1 : 3)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (din.flush),
        .hold       (din.hold),
        .valid_d    (din.valid),
        .R2val_d    (din.r2v),
        .R3val_d    (din.r3v),
        .R2_d       (din.r2),
        .R3_d       (din.r3),
        .DestR_d    (din.dst),
        .ExtndSel_d (din.ext),
        .MemRead_d  (din.mr),
        .RegWrite_d (din.rw),
        .Ctrl_d     (din.ctrl),
        .R2res1     (o_r2res[gi]),
        .R3res1     (o_r3res[gi]),
        .R2_2       (o_r2[gi]),
        .R3_2       (o_r3[gi]),
        .ExtndSel1  (o_ext[gi]),
        .DestR_2    (o_dst[gi]),
        .MemRead_2  (o_mr[gi]),
        .RegWrite_2 (o_rw[gi]),
        .Ctrl_2     (o_ctrl[gi]),
        .valid_2    (o_valid[gi]),
        .stall_d    (o_stall[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int ls(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic stg_t q(input int i);
    stg_t s;
    s.r2v = o_r2res[i]; s.r3v = o_r3res[i]; s.r2 = o_r2[i]; s.r3 = o_r3[i];
    s.ext = o_ext[i]; s.dst = o_dst[i]; s.mr = o_mr[i]; s.rw = o_rw[i];
    s.ctrl = o_ctrl[i]; s.valid = o_valid[i];
    return s;
  endfunction

  function automatic din_t mk(input int v, input int r2v, input int r2, input int r3,
                              input int dst, input int ext, input int mr, input int rw);
    din_t d;
    d.flush = 1'b0; d.hold = 1'b0; d.valid = 1'(v);
    d.r2v = 32'(r2v); d.r3v = ~32'(r2v);
    d.r2 = 4'(r2); d.r3 = 4'(r3); d.dst = 4'(dst); d.ext = 2'(ext);
    d.mr = 1'(mr); d.rw = 1'(rw); d.ctrl = 8'(r2v + 1);
    return d;
  endfunction

  // Model: the instruction in the stage plus the number of forced bubbles still owed.
  function automatic logic m_hazard(input int i);
    stg_t s = m_stg[i];
    logic uses;
    uses = ((din.r2 == s.dst) && din.ext[1]) || ((din.r3 == s.dst) && (din.ext == 2'b10));
    return s.valid && s.mr && s.rw && (s.dst != 4'd0) && din.valid && uses;
  endfunction

  function automatic logic exp_stall(input int i);
    return !din.flush && ((m_left[i] > 0) || m_hazard(i));
  endfunction

  task automatic step(input int i);
    stg_t s;
    if (din.flush) begin
      m_stg[i] = '0; m_left[i] = 0;
    end else if (!din.hold) begin
      if (m_left[i] > 0) begin
        m_stg[i] = '0; m_left[i] = m_left[i] - 1;
      end else if (m_hazard(i)) begin
        m_stg[i] = '0; m_left[i] = ls(i) - 1;
      end else if (din.valid) begin
        s.r2v = din.r2v; s.r3v = din.r3v; s.r2 = din.r2; s.r3 = din.r3;
        s.ext = din.ext; s.dst = din.dst; s.mr = din.mr; s.rw = din.rw;
        s.ctrl = din.ctrl; s.valid = 1'b1;
        m_stg[i] = s;
      end else begin
        m_stg[i] = '0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      last_stall[i] = o_stall[i];
      check($sformatf("stall_d[%0d]", i), 128'(o_stall[i]), 128'(exp_stall(i)));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) step(i);
    #1;
    for (int i = 0; i < 2; i++) check($sformatf("stage[%0d]", i), 128'(q(i)), 128'(m_stg[i]));
  endtask

  task automatic row(input int k, input din_t d, input int st, input int v,
                     input int r2, input int dst, input int r2v);
    tbl[k].in = d; tbl[k].e_stall = 1'(st); tbl[k].e_valid = 1'(v);
    tbl[k].e_r2 = 4'(r2); tbl[k].e_dst = 4'(dst); tbl[k].e_r2v = 32'(r2v);
  endtask

  task automatic count_stalls(input int i, output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (last_stall[i]) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    // Load-use scenarios for the LOAD_STALL=1 instance, with hand-derived results.
    row(0,  mk(1, 32'hAABBCCDD, 3, 0, 5,  0, 0, 1), 0, 1, 3, 5,  32'hAABBCCDD);
    row(1,  mk(1, 32'h11,       1, 0, 4,  0, 1, 1), 0, 1, 1, 4,  32'h11);
    row(2,  mk(1, 32'h22,       4, 0, 7,  2, 0, 1), 1, 0, 0, 0,  0);
    row(3,  mk(1, 32'h22,       4, 0, 7,  2, 0, 1), 0, 1, 4, 7,  32'h22);
    row(4,  mk(1, 32'h33,       0, 0, 6,  0, 1, 1), 0, 1, 0, 6,  32'h33);
    row(5,  mk(1, 32'h44,       1, 6, 8,  2, 0, 1), 1, 0, 0, 0,  0);
    row(6,  mk(1, 32'h44,       1, 6, 8,  2, 0, 1), 0, 1, 1, 8,  32'h44);
    row(7,  mk(1, 32'h55,       0, 0, 6,  0, 1, 1), 0, 1, 0, 6,  32'h55);
    row(8,  mk(1, 32'h66,       1, 6, 9,  3, 0, 1), 0, 1, 1, 9,  32'h66);
    row(9,  mk(1, 32'h77,       0, 0, 6,  0, 1, 1), 0, 1, 0, 6,  32'h77);
    row(10, mk(1, 32'h88,       6, 6, 10, 1, 0, 1), 0, 1, 6, 10, 32'h88);
    row(11, mk(1, 32'h99,       0, 0, 0,  0, 1, 1), 0, 1, 0, 0,  32'h99);
    row(12, mk(1, 32'hA0,       0, 0, 3,  3, 0, 1), 0, 1, 0, 3,  32'hA0);
    row(13, mk(1, 32'hB0,       0, 0, 2,  0, 1, 1), 0, 1, 0, 2,  32'hB0);
    row(14, mk(0, 32'hC0,       2, 0, 1,  2, 0, 1), 0, 0, 0, 0,  0);
    row(15, mk(1, 32'hD0,       2, 0, 1,  2, 0, 1), 0, 1, 2, 1,  32'hD0);

    rst = 1'b1;
    din = '0;
    for (int i = 0; i < 2; i++) begin m_stg[i] = '0; m_left[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_regs[%0d]", i), 128'(q(i)), 128'(0));
      check($sformatf("reset_stall[%0d]", i), 128'(o_stall[i]), 128'(0));
    end
    rst = 1'b0;

    // Asynchronous reset in mid-stream while the stage holds a valid instruction.
    din = mk(1, 32'hDEADBEEF, 1, 2, 3, 2, 0, 1);
    cycle();
    check("pre_rst_valid", 128'(o_valid[0]), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_rst_regs[%0d]", i), 128'(q(i)), 128'(0));
      check($sformatf("async_rst_stall[%0d]", i), 128'(o_stall[i]), 128'(0));
      m_stg[i] = '0; m_left[i] = 0;
    end
    din = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      din = tbl[k].in;
      cycle();
      $display("vec %0d: stall=%0b valid_2=%0b R2_2=%0d DestR_2=%0d R2res1=%08h",
               k, last_stall[0], o_valid[0], o_r2[0], o_dst[0], o_r2res[0]);
      check($sformatf("vec%0d_stall", k), 128'(last_stall[0]), 128'(tbl[k].e_stall));
      check($sformatf("vec%0d_valid", k), 128'(o_valid[0]), 128'(tbl[k].e_valid));
      check($sformatf("vec%0d_r2", k), 128'(o_r2[0]), 128'(tbl[k].e_r2));
      check($sformatf("vec%0d_dst", k), 128'(o_dst[0]), 128'(tbl[k].e_dst));
      check($sformatf("vec%0d_r2v", k), 128'(o_r2res[0]), 128'(tbl[k].e_r2v));
    end

    din = '0;
    repeat (4) cycle();

    // LOAD_STALL=3: three bubbles, then the dependent instruction is captured.
    din = mk(1, 32'h1000, 0, 0, 5, 0, 1, 1);
    cycle();
    din = mk(1, 32'h2000, 5, 0, 12, 2, 0, 1);
    count_stalls(1, n);
    $display("ls3 load-use: stall cycles=%0d R2_2=%0d", n, o_r2[1]);
    check("ls3_stall_cycles", 128'(n), 128'(3));
    check("ls3_capture_valid", 128'(o_valid[1]), 128'(1));
    check("ls3_capture_r2", 128'(o_r2[1]), 128'(5));
    check("ls3_capture_dst", 128'(o_dst[1]), 128'(12));

    // Flush during the second bubble cycle.
    din = mk(1, 32'h1000, 0, 0, 5, 0, 1, 1);
    cycle();
    din = mk(1, 32'h2000, 5, 0, 12, 2, 0, 1);
    cycle();
    check("flush_pre_stall", 128'(last_stall[1]), 128'(1));
    din.flush = 1'b1;
    cycle();
    $display("flush in stall: stall_d=%0b valid_2=%0b", last_stall[1], o_valid[1]);
    check("flush_stall", 128'(last_stall[1]), 128'(0));
    check("flush_bubble", 128'(o_valid[1]), 128'(0));
    din = mk(1, 32'h3000, 9, 0, 11, 0, 0, 1);
    cycle();
    check("post_flush_stall", 128'(last_stall[1]), 128'(0));
    check("post_flush_r2", 128'(o_r2[1]), 128'(9));
    check("post_flush_dst", 128'(o_dst[1]), 128'(11));

    // Hold with the load in the stage, then hold again in the middle of the stall.
    din = mk(1, 32'h12345678, 0, 0, 5, 0, 1, 1);
    cycle();
    check("hold_load_data", 128'(o_r2res[1]), 128'(32'h12345678));
    din = mk(1, 32'h4000, 5, 0, 13, 2, 0, 1);
    din.hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      $display("hold %0d: R2res1=%08h stall_d=%0b", k, o_r2res[1], last_stall[1]);
      check("hold_data", 128'(o_r2res[1]), 128'(32'h12345678));
      check("hold_stall", 128'(last_stall[1]), 128'(1));
    end
    din.hold = 1'b0;
    cycle();
    check("hold_first_bubble", 128'(last_stall[1]), 128'(1));
    check("hold_first_bubble_valid", 128'(o_valid[1]), 128'(0));
    din.hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("midstall_hold_stall", 128'(last_stall[1]), 128'(1));
      check("midstall_hold_valid", 128'(o_valid[1]), 128'(0));
    end
    din.hold = 1'b0;
    count_stalls(1, n);
    $display("hold release: remaining stall cycles=%0d R2_2=%0d", n, o_r2[1]);
    check("hold_remaining_stalls", 128'(n), 128'(2));
    check("hold_capture_r2", 128'(o_r2[1]), 128'(5));
    check("hold_capture_dst", 128'(o_dst[1]), 128'(13));

    // Randomised traffic, small register numbers to provoke frequent hazards.
    for (int k = 0; k < 400; k++) begin
      din.flush = ($urandom_range(0, 19) == 0);
      din.hold  = ($urandom_range(0, 9) == 0);
      din.valid = ($urandom_range(0, 4) != 0);
      din.r2v   = $urandom;
      din.r3v   = $urandom;
      din.r2    = 4'($urandom_range(0, 3));
      din.r3    = 4'($urandom_range(0, 3));
      din.dst   = 4'($urandom_range(0, 3));
      din.ext   = 2'($urandom_range(0, 3));
      din.mr    = 1'($urandom_range(0, 1));
      din.rw    = ($urandom_range(0, 3) != 0);
      din.ctrl  = 8'($urandom_range(0, 255));
      cycle();
      if (k % 50 == 0)
        $display("random %0d: stall=%0b/%0b valid_2=%0b/%0b", k,
                 last_stall[0], last_stall[1], o_valid[0], o_valid[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
